// File: rtl/oddr_tx.sv
// oddr_tx: source-synchronous DDR output transmitter.
//
// Parallel words enter through a valid/ready handshake into a DEPTH-entry FIFO.
// The shifter sends each word MSB-first on Q, two bits per clock. The first bit
// of a pair goes out while C is high and the second while C is low. Q_en marks
// every clock that carries word bits. Q_fs marks the first beat of each word.
//
// Optional feature: define ODDR_TX_PARITY_EN to append one parity beat to each
// word. The rise phase carries the even parity and the fall phase carries its
// complement.
//
// Ports:
//   C          clock; all state on posedge, fall-phase output register on negedge
//   R          asynchronous active-high reset
//   CE         clock enable; low holds all posedge state
//   din        parallel word
//   din_valid  din holds a word
//   din_ready  CE & ~fifo_full; transfer when din_valid & din_ready at posedge
//   Q          DDR data (rise_q while C=1, fall_q while C=0)
//   Q_en       high for every clock whose two Q phases carry word bits
//   Q_fs       high for the first beat of each word
//   busy       FIFO non-empty or shifter active
module oddr_tx #(
  parameter int unsigned WIDTH    = 8,    // even, >= 4
  parameter int unsigned DEPTH    = 4,    // power of two, >= 2
  parameter logic        IDLE_VAL = 1'b0
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             Q,
  output logic             Q_en,
  output logic             Q_fs,
  output logic             busy
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned Beats = WIDTH / 2;
`ifdef ODDR_TX_PARITY_EN
  localparam int unsigned NumBeats = Beats + 1;
`else
  localparam int unsigned NumBeats = Beats;
`endif
  localparam int unsigned BeatW = $clog2(NumBeats);
  localparam logic [BeatW-1:0] EndBeat  = BeatW'(NumBeats - 1);
`ifdef ODDR_TX_PARITY_EN
  localparam logic [BeatW-1:0] LastData = BeatW'(Beats - 1);
`endif

  typedef enum logic {StIdle, StShift} state_e;

  // FIFO
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             fifo_full, fifo_empty;
  logic             push, pop, load;
  logic [WIDTH-1:0] head;

  // Shifter and output registers
  state_e           state_q;
  logic [BeatW-1:0] beat_q;
  logic [WIDTH-1:0] s_q;
  logic             rise_q;
  logic             fall_pre_q;  // fall-phase bit chosen at posedge
  logic             fall_q;      // fall-phase bit launched at negedge
  logic             q_en_q, q_fs_q;
`ifdef ODDR_TX_PARITY_EN
  logic             par_q;
`endif

  assign fifo_full  = (count_q == CntW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign din_ready  = CE & ~fifo_full;
  assign push       = din_valid & din_ready;
  assign head       = mem_q[rd_ptr_q];

  // Pop from idle, or on the last beat of a word so the next word follows without a gap.
  // Uses the pre-edge count, so a word written this edge cannot be popped until the next.
  assign load = ~fifo_empty & ((state_q == StIdle) | (beat_q == EndBeat));
  assign pop  = CE & load;

  always_ff @(posedge C) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state_q    <= StIdle;
      beat_q     <= '0;
      s_q        <= '0;
      rise_q     <= IDLE_VAL;
      fall_pre_q <= IDLE_VAL;
      q_en_q     <= 1'b0;
      q_fs_q     <= 1'b0;
`ifdef ODDR_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else if (CE) begin
      if (load) begin
        // Beat 0 goes straight from the FIFO head; the shifter keeps the rest.
        state_q    <= StShift;
        beat_q     <= '0;
        s_q        <= head << 2;
        rise_q     <= head[WIDTH-1];
        fall_pre_q <= head[WIDTH-2];
        q_en_q     <= 1'b1;
        q_fs_q     <= 1'b1;
`ifdef ODDR_TX_PARITY_EN
        par_q      <= ^head;
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
          end
          StShift: begin
            q_fs_q <= 1'b0;
            if (beat_q == EndBeat) begin
              state_q    <= StIdle;
              beat_q     <= '0;
              rise_q     <= IDLE_VAL;
              fall_pre_q <= IDLE_VAL;
              q_en_q     <= 1'b0;
            end
`ifdef ODDR_TX_PARITY_EN
            else if (beat_q == LastData) begin
              rise_q     <= par_q;
              fall_pre_q <= ~par_q;
              beat_q     <= beat_q + BeatW'(1);
            end
`endif
            else begin
              rise_q     <= s_q[WIDTH-1];
              fall_pre_q <= s_q[WIDTH-2];
              s_q        <= s_q << 2;
              beat_q     <= beat_q + BeatW'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Recapturing fall_pre_q every negedge makes a CE stall repeat the same pair.
  always_ff @(negedge C or posedge R) begin
    if (R) begin
      fall_q <= IDLE_VAL;
    end else begin
      fall_q <= fall_pre_q;
    end
  end

  assign Q    = C ? rise_q : fall_q;
  assign Q_en = q_en_q;
  assign Q_fs = q_fs_q;
  assign busy = (count_q != '0) | (state_q == StShift);

endmodule

// File: tb/tb_oddr_tx.sv
// Self-checking bench for oddr_tx. A queue-based reference model predicts every output.
// Directed sequences with literal expectations pin the model.
module tb_oddr_tx;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam logic        IV = 1'b0;
`ifdef ODDR_TX_PARITY_EN
  localparam int unsigned BPW = W / 2 + 1;
`else
  localparam int unsigned BPW = W / 2;
`endif

  logic         C = 1'b0;
  logic         R, CE, din_valid, din_ready, Q, Q_en, Q_fs, busy;
  logic [W-1:0] din;

  oddr_tx #(
    .WIDTH   (W),
    .DEPTH   (D),
    .IDLE_VAL(IV)
  ) dut (
    .C        (C),
    .R        (R),
    .CE       (CE),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .Q        (Q),
    .Q_en     (Q_en),
    .Q_fs     (Q_fs),
    .busy     (busy)
  );

  always #5 C = ~C;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: FIFO of words plus a queue of pending beats for the word on the wire.
  typedef struct packed {logic r; logic f; logic fs;} beat_t;
  logic [W-1:0] m_fifo[$];
  beat_t        m_beats[$];
  logic         e_r, e_f, e_en, e_fs;

  task automatic model_reset();
    m_fifo.delete();
    m_beats.delete();
    e_r  = IV;
    e_f  = IV;
    e_en = 1'b0;
    e_fs = 1'b0;
  endtask

  task automatic model_edge();
    beat_t        b;
    logic [W-1:0] w;
    logic         push;
    if (!CE) return;
    push = din_valid && (m_fifo.size() < D);
    if (m_beats.size() == 0 && m_fifo.size() != 0) begin
      w = m_fifo.pop_front();
      for (int i = 0; i < W / 2; i++) begin
        m_beats.push_back('{r: w[W-1-2*i], f: w[W-2-2*i], fs: (i == 0)});
      end
`ifdef ODDR_TX_PARITY_EN
      m_beats.push_back('{r: ^w, f: ~^w, fs: 1'b0});
`endif
    end
    if (m_beats.size() != 0) begin
      b    = m_beats.pop_front();
      e_r  = b.r;
      e_f  = b.f;
      e_fs = b.fs;
      e_en = 1'b1;
    end else begin
      e_r  = IV;
      e_f  = IV;
      e_fs = 1'b0;
      e_en = 1'b0;
    end
    if (push) m_fifo.push_back(din);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge C or posedge R);
      if (R) model_reset();
      else   model_edge();
    end
  end

  // Compare process: high phase at posedge+3, low phase at negedge+2.
  logic cmp_on = 1'b0;
  initial begin
    wait (cmp_on);
    forever begin
      @(posedge C);
      #3;
      check("q_rise", Q, e_r);
      check("q_en", Q_en, e_en);
      check("q_fs", Q_fs, e_fs);
      check("busy", busy, (m_fifo.size() != 0) || e_en);
      check("din_ready", din_ready, CE && (m_fifo.size() < D));
      @(negedge C);
      #2;
      check("q_fall", Q, e_f);
    end
  end

  // One clock of stimulus, entered and left at negedge+1. Records the handshake and
  // the outputs that follow the edge.
  logic acc, h_en, h_fs, h_r, l_f;
  task automatic cyc(input logic ce, input logic v, input logic [W-1:0] d);
    CE        = ce;
    din_valid = v;
    din       = d;
    #1;
    acc = v && din_ready;
    @(posedge C);
    #2;
    h_en = Q_en;
    h_fs = Q_fs;
    h_r  = Q;
    @(negedge C);
    #1;
    l_f = Q;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0]   ven, vfs, vr, vf;
  logic [127:0] stream, exp_s;
  logic [15:0]  fsm;
  logic [W-1:0] bw[3];
  logic [W-1:0] fw[8];
  int           idx, nen, runs, first_block, nacc;
  logic         prev_en;

  initial begin
    R = 1'b1; CE = 1'b0; din_valid = 1'b0; din = '0;
    repeat (3) @(posedge C);
    #2;
    check("rst_q_en", Q_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge C);
    #1;
    R = 1'b0;
    cmp_on = 1'b1;

    // Single word 0xA5.
    cyc(1'b1, 1'b1, 8'hA5);
    check("a5_accept", acc, 1'b1);
    check("a5_en_at_k", h_en, 1'b0);
    ven = '0; vfs = '0; vr = '0; vf = '0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, '0);
      ven = {ven[6:0], h_en}; vfs = {vfs[6:0], h_fs};
      vr  = {vr[6:0], h_r};   vf  = {vf[6:0], l_f};
    end
`ifdef ODDR_TX_PARITY_EN
    check("a5_en", ven[5:0], 6'b111110);
    check("a5_fall", vf[5:0], 6'b001110);
`else
    check("a5_en", ven[5:0], 6'b111100);
    check("a5_fall", vf[5:0], 6'b001100);
`endif
    check("a5_fs", vfs[5:0], 6'b100000);
    check("a5_rise", vr[5:0], 6'b110000);
    repeat (4) cyc(1'b1, 1'b0, '0);

    // Back-to-back 0x3C, 0xFF, 0x00.
    bw[0] = 8'h3C; bw[1] = 8'hFF; bw[2] = 8'h00;
    idx = 0; nen = 0; runs = 0; prev_en = 1'b0; stream = '0; fsm = '0;
    for (int n = 0; n < 30; n++) begin
      if (idx < 3) cyc(1'b1, 1'b1, bw[idx]);
      else         cyc(1'b1, 1'b0, '0);
      if (acc) idx++;
      if (h_en) begin
        nen++;
        stream = {stream[125:0], h_r, l_f};
        fsm    = {fsm[14:0], h_fs};
        if (!prev_en) runs++;
      end
      prev_en = h_en;
    end
    check("b2b_accepted", idx, 3);
    check("b2b_runs", runs, 1);
    check("b2b_en_cycles", nen, 3 * BPW);
`ifdef ODDR_TX_PARITY_EN
    check("b2b_stream", stream, {8'h3C, 2'b01, 8'hFF, 2'b01, 8'h00, 2'b01});
    check("b2b_fs", fsm, 15'b100001000010000);
`else
    check("b2b_stream", stream, 24'h3CFF00);
    check("b2b_fs", fsm, 12'b100010001000);
`endif

    // Full / backpressure with 8 words held valid.
    exp_s = '0;
    for (int i = 0; i < 8; i++) begin
      fw[i] = W'($urandom);
      exp_s = {exp_s[119:0], fw[i]};
`ifdef ODDR_TX_PARITY_EN
      exp_s = {exp_s[125:0], ^fw[i], ~^fw[i]};
`endif
    end
    idx = 0; nen = 0; first_block = -1; stream = '0;
    for (int n = 0; n < 70; n++) begin
      if (idx < 8) cyc(1'b1, 1'b1, fw[idx]);
      else         cyc(1'b1, 1'b0, '0);
      if (acc) idx++;
      else if (idx < 8 && first_block < 0) first_block = idx;
      if (h_en) begin
        nen++;
        stream = {stream[125:0], h_r, l_f};
      end
    end
    check("full_first_block", first_block, 5);
    check("full_accepted", idx, 8);
    check("full_en_cycles", nen, 8 * BPW);
    check("full_stream", stream, exp_s);

    // CE stall at beat 1 of 0xA5.
    cyc(1'b1, 1'b1, 8'hA5);
    ven = '0; vfs = '0; vr = '0; vf = '0; nacc = 0;
    for (int i = 0; i < 8; i++) begin
      if (i >= 2 && i < 5) begin
        cyc(1'b0, 1'b1, 8'h5A);
        if (acc) nacc++;
      end else begin
        cyc(1'b1, 1'b0, '0);
      end
      ven = {ven[6:0], h_en}; vfs = {vfs[6:0], h_fs};
      vr  = {vr[6:0], h_r};   vf  = {vf[6:0], l_f};
    end
    check("stall_no_accept", nacc, 0);
    check("stall_rise", vr, 8'b11111000);
    check("stall_fs", vfs, 8'b10000000);
`ifdef ODDR_TX_PARITY_EN
    check("stall_en", ven, 8'b11111111);
    check("stall_fall", vf, 8'b00000111);
`else
    check("stall_en", ven, 8'b11111110);
    check("stall_fall", vf, 8'b00000110);
`endif
    repeat (4) cyc(1'b1, 1'b0, '0);

`ifdef ODDR_TX_PARITY_EN
    // Parity beats: 0x07 has odd weight, 0x03 even.
    cyc(1'b1, 1'b1, 8'h07);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, '0);
    check("par07_en", h_en, 1'b1);
    check("par07_rise", h_r, 1'b1);
    check("par07_fall", l_f, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 8'h03);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, '0);
    check("par03_fs", h_fs, 1'b0);
    check("par03_rise", h_r, 1'b0);
    check("par03_fall", l_f, 1'b1);
    repeat (3) cyc(1'b1, 1'b0, '0);
`endif

    // Reset mid-clock with words queued.
    cyc(1'b1, 1'b1, 8'h81);
    cyc(1'b1, 1'b1, 8'h42);
    cyc(1'b1, 1'b1, 8'h24);
    R = 1'b1;
    #1;
    check("rst_mid_en", Q_en, 1'b0);
    check("rst_mid_fs", Q_fs, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_q_low", Q, IV);
    @(posedge C);
    #1;
    check("rst_mid_q_high", Q, IV);
    #1;
    R = 1'b0;
    @(negedge C);
    #1;
    nen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, '0);
      if (h_en) nen++;
    end
    check("rst_no_partial", nen, 0);

    // Randomized traffic, with one reset pulse in the middle.
    for (int n = 0; n < 800; n++) begin
      cyc(($urandom_range(0, 99) < 85), 1'(($urandom_range(0, 1))), W'($urandom));
      if (n == 400) begin
        R = 1'b1;
        #2;
        R = 1'b0;
      end
    end
    repeat (30) cyc(1'b1, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
